alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//   Shares one alu instance between NREQ requesters (e.g. the ex stage and the branch-compare unit).
//   - Round-robin arbitration; accepted ops pass through a 3-state FSM.
//   - Results return on one shared response channel, tagged with the requester index.
//   - Instantiates the alu and drives it directly; alu_control is not used here.
// PARAMETERS
//   NREQ   2   number of requesters (2..8)
//   IDW    1   width of rsp_id; must equal clog2(NREQ), minimum 1
// PORTS
//   clk        in   1          single clock, rising edge
//   rst        in   1          asynchronous, active-high reset
//   req_valid  in   NREQ       per-requester op valid
//   req_ready  out  NREQ       per-requester accept; one-hot or zero
//   req_ctl    in   4*NREQ     alu ctl code, requester i at [4i+3:4i]
//   req_a      in   32*NREQ    operand a, requester i at [32i+31:32i]
//   req_b      in   32*NREQ    operand b, same packing as req_a
//   rsp_valid  out  1          response valid
//   rsp_ready  in   1          response consumed
//   rsp_id     out  IDW        index of the requester that owns the response
//   rsp_out    out  32         alu result
//   rsp_zero   out  1          alu zero flag
//   rsp_err    out  1          illegal ctl; only when ALU_ARB_CTL_CHECK_EN is defined, else tied 0
// BEHAVIOUR
//   - FSM states: IDLE -> EXEC -> RESP -> IDLE.
//   - IDLE:
//     - If any req_valid is set, grant the first set bit at or after rr_ptr (wrapping).
//     - req_ready[g] is combinational in IDLE only, so the handshake completes that cycle.
//     - On the handshake, latch ctl/a/b/id into op registers and go to EXEC.
//   - EXEC: the op registers drive the alu; alu out/zero are latched into the rsp registers; go to RESP.
//   - RESP:
//     - rsp_valid=1; all rsp_* are held stable until rsp_valid&&rsp_ready.
//     - On that handshake: go to IDLE and set rr_ptr = granted id + 1, wrapping at NREQ-1 -> 0.
//   - Latency and throughput:
//     - Accept-to-rsp_valid latency is 2 cycles.
//     - Maximum throughput is one op per 3 cycles.
//     - req_ready is 0 in EXEC and RESP.
//   - rsp_ready may be held high before rsp_valid; it has no effect outside RESP.
//   - req_valid may drop without a handshake and no state changes; requesters should hold it until ready.
//   - Simultaneous requests: round-robin only; no requester waits more than NREQ grants.
//   - Reset (at any time, including mid-EXEC or mid-RESP):
//     - state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_out=0, rsp_zero=0, rsp_err=0.
//     - Op registers cleared; any in-flight op is lost.
//   - Unknown ctl codes reach the alu unchanged; the alu returns 0, so zero=1.
// CONFIGURATION
//   ALU_ARB_CTL_CHECK_EN
//   - Defined:
//     - Legal ctl codes are {0,1,2,6,7,12,13}.
//     - An illegal code goes IDLE -> RESP directly, skipping EXEC.
//     - The response has rsp_err=1, rsp_out=0, rsp_zero=0.
//   - Undefined: no check; rsp_err is constant 0; illegal codes take the normal path.
// STRUCTURE
//   - Package alu_arb_pkg holds:
//     - state encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2;
//     - ALU ctl localparams ADD=2, AND=0, OR=1, SUB=6, SLT=7, NOR=12, XOR=13;
//     - a function is_legal_ctl(ctl).
//   - One sub-module, rr_pick: combinational round-robin grant (req vector + ptr -> one-hot grant + index).
//   - The alu is instantiated once inside alu_arbiter.
// TESTING
//   - Reset: assert rst mid-EXEC -> next cycle rsp_valid=0, req_ready=0 with no requests; after release, an idle req0 gets req_ready[0]=1.
//   - Single op: req0 ADD a=5 b=7 -> 2 cycles after accept rsp_valid=1, rsp_id=0, rsp_out=12, rsp_zero=0.
//   - Fairness: req0 and req1 both held valid for 6 ops -> grants alternate 0,1,0,1,0,1.
//   - Backpressure: rsp_ready=0 for 5 cycles on SUB a=9 b=9 -> rsp_out=0, rsp_zero=1 held stable; req_ready stays 0 throughout.
//   - SLT signed: a=32'hFFFFFFFF b=1 -> rsp_out=1; a=32'h7FFFFFFF b=32'h80000000 -> rsp_out=0.
//   - CTL check: with ALU_ARB_CTL_CHECK_EN, ctl=4'd3 -> rsp_valid 1 cycle after accept, rsp_err=1; without it, the same op returns rsp_out=0, rsp_zero=1, rsp_err=0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: FSM state encoding, ALU control codes,
// and the control-code legality check used when ALU_ARB_CTL_CHECK_EN is defined.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] AND = 4'd0;
    localparam logic [3:0] OR  = 4'd1;
    localparam logic [3:0] ADD = 4'd2;
    localparam logic [3:0] SUB = 4'd6;
    localparam logic [3:0] SLT = 4'd7;
    localparam logic [3:0] NOR = 4'd12;
    localparam logic [3:0] XOR = 4'd13;

    function automatic logic is_legal_ctl(input logic [3:0] ctl);
        logic legal;
        legal = 1'b0;
        case (ctl)
            AND, OR, ADD, SUB, SLT, NOR, XOR: legal = 1'b1;
            default:                          legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU; unknown control codes produce a zero result.
module alu
    import alu_arb_pkg::*;
(
    input  logic [3:0]  ctl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (ctl)
            AND:     result = a & b;
            OR:      result = a | b;
            ADD:     result = a + b;
            SUB:     result = a - b;
            SLT:     result = {31'd0, ($signed(a) < $signed(b))};
            NOR:     result = ~(a | b);
            XOR:     result = a ^ b;
            default: result = '0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: grants the first request at or after ptr,
// wrapping to the lowest request when nothing at or above ptr is pending.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic           hi_found;
    logic [IDW-1:0] hi_idx;
    logic [IDW-1:0] lo_idx;

    // Scan downwards so the lowest qualifying index is the one left standing.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        any      = 1'b0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req[j[IDW-1:0]]) begin
                any    = 1'b1;
                lo_idx = j[IDW-1:0];
                if (j >= int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = j[IDW-1:0];
                end
            end
        end
        idx   = hi_found ? hi_idx : lo_idx;
        grant = any ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters (IDLE -> EXEC -> RESP).
// Optional macro ALU_ARB_CTL_CHECK_EN: illegal ctl codes skip EXEC and respond with rsp_err=1.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_ctl,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_out,
    output logic              rsp_zero,
    output logic              rsp_err
);

    state_t         state;
    state_t         next_state;
    logic [IDW-1:0] rr_ptr;
    logic [NREQ-1:0] pick_grant;
    logic [IDW-1:0] pick_idx;
    logic           pick_any;
    logic [3:0]     sel_ctl;
    logic [31:0]    sel_a;
    logic [31:0]    sel_b;
    logic           sel_legal;
    logic [3:0]     op_ctl;
    logic [31:0]    op_a;
    logic [31:0]    op_b;
    logic [IDW-1:0] op_id;
    logic [31:0]    alu_result;
    logic           alu_zero;
    logic           accept;
    logic           rsp_done;

    rr_pick #(
        .NREQ(NREQ),
        .IDW (IDW)
    ) u_pick (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .grant(pick_grant),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    alu u_alu (
        .ctl   (op_ctl),
        .a     (op_a),
        .b     (op_b),
        .result(alu_result),
        .zero  (alu_zero)
    );

    assign sel_ctl   = req_ctl[int'(pick_idx)*4 +: 4];
    assign sel_a     = req_a[int'(pick_idx)*32 +: 32];
    assign sel_b     = req_b[int'(pick_idx)*32 +: 32];
    assign req_ready = (state == IDLE) ? pick_grant : '0;
    assign accept    = (state == IDLE) && pick_any;
    assign rsp_valid = (state == RESP);
    assign rsp_done  = rsp_valid && rsp_ready;

`ifdef ALU_ARB_CTL_CHECK_EN
    assign sel_legal = is_legal_ctl(sel_ctl);
`else
    assign sel_legal = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = sel_legal ? EXEC : RESP;
            EXEC:    next_state = RESP;
            RESP:    if (rsp_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_ctl <= '0;
            op_a   <= '0;
            op_b   <= '0;
            op_id  <= '0;
        end else if (accept) begin
            op_ctl <= sel_ctl;
            op_a   <= sel_a;
            op_b   <= sel_b;
            op_id  <= pick_idx;
        end
    end

    // Response registers only change when a new result is produced, so they
    // stay stable for the whole RESP wait under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_out  <= '0;
            rsp_zero <= 1'b0;
            rsp_id   <= '0;
        end else if (state == EXEC) begin
            rsp_out  <= alu_result;
            rsp_zero <= alu_zero;
            rsp_id   <= op_id;
        end else if (accept && !sel_legal) begin
            rsp_out  <= '0;
            rsp_zero <= 1'b0;
            rsp_id   <= pick_idx;
        end
    end

`ifdef ALU_ARB_CTL_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == EXEC) begin
            err_q <= 1'b0;
        end else if (accept && !sel_legal) begin
            err_q <= 1'b1;
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (rsp_done) begin
            rr_ptr <= (op_id == IDW'(NREQ - 1)) ? '0 : op_id + IDW'(1);
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter (NREQ=2) against a behavioural model.
// Honours ALU_ARB_CTL_CHECK_EN the same way as the design.
module tb_alu_arbiter;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [4*NREQ-1:0]  req_ctl;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_out;
    logic               rsp_zero;
    logic               rsp_err;

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;

    alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_ctl  (req_ctl),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_out  (rsp_out),
        .rsp_zero (rsp_zero),
        .rsp_err  (rsp_err)
    );

    always #5 clk = ~clk;

    function automatic bit ref_legal(input logic [3:0] ctl);
        int legal_codes[7] = '{0, 1, 2, 6, 7, 12, 13};
        foreach (legal_codes[i]) if (int'(ctl) == legal_codes[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (int'(ctl))
            0:  return a & b;
            1:  return a | b;
            2:  return a + b;
            6:  return a - b;
            7:  return (sa < sb) ? 32'd1 : 32'd0;
            12: return ~(a | b);
            13: return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    // Expected response fields and latency for one op.
    task automatic ref_rsp(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] e_out, output logic e_zero, output logic e_err, output int e_lat);
        e_out  = ref_alu(ctl, a, b);
        e_zero = (e_out == 32'd0);
        e_err  = 1'b0;
        e_lat  = 2;
`ifdef ALU_ARB_CTL_CHECK_EN
        if (!ref_legal(ctl)) begin
            e_out  = 32'd0;
            e_zero = 1'b0;
            e_err  = 1'b1;
            e_lat  = 1;
        end
`endif
    endtask

    function automatic logic [3:0] rand_ctl();
        logic [3:0] codes[8] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd13, 4'd3};
        return codes[$urandom_range(0, 7)];
    endfunction

    task automatic drive_op(input int id, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        req_ctl[id*4 +: 4]  = ctl;
        req_a[id*32 +: 32]  = a;
        req_b[id*32 +: 32]  = b;
    endtask

    // Present an op and wait (bounded) for its handshake; returns #1 after the accepting edge.
    task automatic issue(input int id, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b, output bit ok);
        drive_op(id, ctl, a, b);
        req_valid[id] = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (req_ready[id]) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        req_valid[id] = 1'b0;
    endtask

    // Wait (bounded) for rsp_valid and capture the response without consuming it.
    task automatic collect(input int max_cycles, output bit ok, output int lat, output logic [IDW-1:0] id,
                           output logic [31:0] out, output logic zero, output logic err);
        ok = 1'b0; lat = 0; id = '0; out = '0; zero = 1'b0; err = 1'b0;
        for (int c = 1; c <= max_cycles && !ok; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1; lat = c; id = rsp_id; out = rsp_out; zero = rsp_zero; err = rsp_err;
            end
        end
    endtask

    task automatic consume(input logic [IDW-1:0] id);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        model_ptr = (int'(id) + 1) % NREQ;
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_ctl = '0; req_a = '0; req_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_out !== 32'd0 || rsp_zero !== 1'b0 || rsp_err !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: got valid=%b id=%0d out=%0h zero=%b err=%b ready=%b expected all zero",
                     rsp_valid, rsp_id, rsp_out, rsp_zero, rsp_err, req_ready);
        end
        @(posedge clk); #1; rst = 1'b0; model_ptr = 0;

        issue(0, 4'd2, 32'd1, 32'd2, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL reset_pre_accept: got no handshake expected handshake"); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== '0 || rsp_out !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_exec: got valid=%b ready=%b out=%0h expected 0 0 0", rsp_valid, req_ready, rsp_out);
        end
        @(posedge clk); #1; rst = 1'b0; model_ptr = 0;
        drive_op(0, 4'd2, 32'd3, 32'd4);
        req_valid[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL reset_idle_ready: got %b expected 01", req_ready); end
        req_valid = '0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_dropped_valid: got rsp_valid=%b expected 0", rsp_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_op();
        bit ok; int lat; logic [IDW-1:0] id; logic [31:0] out; logic zero, err;
        issue(0, 4'd2, 32'd5, 32'd7, ok);
        collect(6, ok, lat, id, out, zero, err);
        checks++;
        if (!ok || lat != 2 || id !== 1'b0 || out !== 32'd12 || zero !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_add: got ok=%0d lat=%0d id=%0d out=%0d zero=%b err=%b expected 1 2 0 12 0 0",
                     ok, lat, id, out, zero, err);
        end
        consume(id);
    endtask

    task automatic test_fairness();
        logic [3:0] c[NREQ]; logic [31:0] a[NREQ], b[NREQ];
        logic [31:0] e_out; logic e_zero, e_err; int e_lat;
        bit ok; int lat, g, prev_g; logic [IDW-1:0] id; logic [31:0] out; logic zero, err;
        prev_g = -1;
        for (int r = 0; r < NREQ; r++) begin
            c[r] = rand_ctl(); a[r] = $urandom(); b[r] = $urandom();
            drive_op(r, c[r], a[r], b[r]);
        end
        req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            ok = 1'b0;
            for (int w = 0; w < 20 && !ok; w++) begin
                @(negedge clk);
                if (req_ready != '0) ok = 1'b1;
            end
            g = req_ready[1] ? 1 : 0;
            checks++;
            if (!ok || req_ready !== NREQ'(1 << model_ptr) || g == prev_g) begin
                errors++;
                $display("[TB] FAIL fair_grant[%0d]: got ready=%b expected %b (previous grant %0d)",
                         k, req_ready, NREQ'(1 << model_ptr), prev_g);
            end
            ref_rsp(c[g], a[g], b[g], e_out, e_zero, e_err, e_lat);
            @(posedge clk); #1;
            c[g] = rand_ctl(); a[g] = $urandom(); b[g] = $urandom();
            drive_op(g, c[g], a[g], b[g]);
            collect(6, ok, lat, id, out, zero, err);
            checks++;
            if (!ok || lat != e_lat || int'(id) != g || out !== e_out || zero !== e_zero || err !== e_err) begin
                errors++;
                $display("[TB] FAIL fair_rsp[%0d]: got lat=%0d id=%0d out=%0h zero=%b err=%b expected %0d %0d %0h %b %b",
                         k, lat, id, out, zero, err, e_lat, g, e_out, e_zero, e_err);
            end
            consume(id);
            prev_g = g;
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        bit ok; int lat; logic [IDW-1:0] id; logic [31:0] out; logic zero, err;
        rsp_ready = 1'b0;
        issue(1, 4'd6, 32'd9, 32'd9, ok);
        drive_op(0, 4'd2, 32'd1, 32'd1);
        req_valid = '1;
        @(negedge clk);
        checks++;
        if (req_ready !== '0 || rsp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_exec: got ready=%b valid=%b expected 00 0", req_ready, rsp_valid);
        end
        collect(4, ok, lat, id, out, zero, err);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (!ok || rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_out !== 32'd0 || rsp_zero !== 1'b1 || req_ready !== '0) begin
                errors++;
                $display("[TB] FAIL bp_hold[%0d]: got valid=%b id=%0d out=%0h zero=%b ready=%b expected 1 1 0 1 00",
                         k, rsp_valid, rsp_id, rsp_out, rsp_zero, req_ready);
            end
        end
        req_valid = '0;
        consume(1'b1);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release: got rsp_valid=%b expected 0", rsp_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_slt_signed();
        bit ok; int lat; logic [IDW-1:0] id; logic [31:0] out; logic zero, err;
        issue(0, 4'd7, 32'hFFFF_FFFF, 32'd1, ok);
        collect(6, ok, lat, id, out, zero, err);
        checks++;
        if (!ok || out !== 32'd1 || zero !== 1'b0) begin
            errors++; $display("[TB] FAIL slt_neg: got out=%0h zero=%b expected 1 0", out, zero);
        end
        consume(id);
        issue(1, 4'd7, 32'h7FFF_FFFF, 32'h8000_0000, ok);
        collect(6, ok, lat, id, out, zero, err);
        checks++;
        if (!ok || out !== 32'd0 || zero !== 1'b1 || id !== 1'b1) begin
            errors++; $display("[TB] FAIL slt_pos: got out=%0h zero=%b id=%0d expected 0 1 1", out, zero, id);
        end
        consume(id);
    endtask

    task automatic test_ctl_check();
        bit ok; int lat; logic [IDW-1:0] id; logic [31:0] out; logic zero, err;
        logic [31:0] e_out; logic e_zero, e_err; int e_lat;
        ref_rsp(4'd3, 32'h1234, 32'h5678, e_out, e_zero, e_err, e_lat);
        issue(0, 4'd3, 32'h1234, 32'h5678, ok);
        collect(6, ok, lat, id, out, zero, err);
        checks++;
        if (!ok || lat != e_lat || out !== e_out || zero !== e_zero || err !== e_err) begin
            errors++;
            $display("[TB] FAIL ctl_illegal: got lat=%0d out=%0h zero=%b err=%b expected %0d %0h %b %b",
                     lat, out, zero, err, e_lat, e_out, e_zero, e_err);
        end
        consume(id);
    endtask

    task automatic test_random();
        logic [3:0] c[NREQ]; logic [31:0] a[NREQ], b[NREQ];
        logic [31:0] e_out; logic e_zero, e_err; int e_lat;
        bit ok; int lat, g, d; logic [NREQ-1:0] vec; logic [IDW-1:0] id; logic [31:0] out; logic zero, err;
        for (int k = 0; k < 30; k++) begin
            vec = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int r = 0; r < NREQ; r++) begin
                c[r] = rand_ctl(); a[r] = $urandom(); b[r] = $urandom();
                if ($urandom_range(0, 3) == 0) b[r] = a[r];
                drive_op(r, c[r], a[r], b[r]);
            end
            g = -1;
            for (int s = 0; s < NREQ && g < 0; s++)
                if (vec[(model_ptr + s) % NREQ]) g = (model_ptr + s) % NREQ;
            req_valid = vec;
            @(negedge clk);
            checks++;
            if (req_ready !== NREQ'(1 << g)) begin
                errors++; $display("[TB] FAIL rand_grant[%0d]: got %b expected %b", k, req_ready, NREQ'(1 << g));
            end
            @(posedge clk); #1;
            req_valid = '0;
            ref_rsp(c[g], a[g], b[g], e_out, e_zero, e_err, e_lat);
            collect(6, ok, lat, id, out, zero, err);
            d = $urandom_range(0, 3);
            repeat (d) @(negedge clk);
            checks++;
            if (!ok || lat != e_lat || int'(id) != g || out !== e_out || zero !== e_zero || err !== e_err
                || rsp_out !== e_out || rsp_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rand_rsp[%0d]: got lat=%0d id=%0d out=%0h zero=%b err=%b expected %0d %0d %0h %b %b",
                         k, lat, id, out, zero, err, e_lat, g, e_out, e_zero, e_err);
            end
            consume(id);
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_fairness();
        test_backpressure();
        test_slt_signed();
        test_ctl_check();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
